// File: rtl/mem_nib_pkg.sv
// Shared codes, state encoding and nibble/position helpers for the nibble-serial memory link.
package mem_nib_pkg;

    localparam logic [1:0] MT_NONE = 2'b00;
    localparam logic [1:0] MT_BYTE = 2'b01;
    localparam logic [1:0] MT_HALF = 2'b10;
    localparam logic [1:0] MT_WORD = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SEND    = 3'd1;
    localparam state_t ST_COLLECT = 3'd2;
    localparam state_t ST_COMMIT  = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    function automatic logic [3:0] nib_count(input logic [1:0] mem_type);
        case (mem_type)
            MT_BYTE: return 4'd2;
            MT_HALF: return 4'd4;
            MT_WORD: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Index k travels as {k[0], k[2:1]} so the low nibble of each byte goes first.
    function automatic logic [2:0] pos_enc(input logic [2:0] k);
        return {k[0], k[2:1]};
    endfunction

    function automatic logic [2:0] pos_dec(input logic [2:0] code);
        return {code[1:0], code[2]};
    endfunction

    function automatic logic [3:0] byte_mask(input logic [3:0] nibs);
        case (nibs)
            4'd2:    return 4'b0001;
            4'd4:    return 4'b0011;
            4'd8:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_nibble_responder_if.sv
// Nibble-serial memory link between the controller (master) and the memory responder (slave).
interface mem_nibble_responder_if;

    logic        reqValid;
    logic        reqWrite;
    logic [23:0] spiAddr;
    logic [1:0]  memType;
    logic        wrValid;
    logic [3:0]  memDataIn;
    logic [2:0]  dataPosIn;
    logic [3:0]  memDataOut;
    logic [2:0]  dataPosOut;
    logic        nibValid;
    logic        memReady;
    logic        busy;
    logic        protoErr;

    modport master (
        output reqValid, reqWrite, spiAddr, memType, wrValid, memDataIn, dataPosIn,
        input  memDataOut, dataPosOut, nibValid, memReady, busy, protoErr
    );

    modport slave (
        input  reqValid, reqWrite, spiAddr, memType, wrValid, memDataIn, dataPosIn,
        output memDataOut, dataPosOut, nibValid, memReady, busy, protoErr
    );

endinterface

// File: rtl/nib_byte_store.sv
// Byte array with four async read lanes and four sync write lanes at consecutive,
// wrapping addresses; contents are never reset.
module nib_byte_store #(
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0][7:0]   rd_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_en,
    input  logic [3:0][7:0]   wr_data
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [7:0] mem [Depth];

    for (genvar i = 0; i < 4; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra         = rd_addr + ADDR_W'(i);
        assign rd_data[i] = mem[ra];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem[wr_addr + ADDR_W'(i)] <= wr_data[i];
        end
    end

endmodule

// File: rtl/mem_nibble_responder.sv
// Memory-side responder for the nibble-serial link: streams load nibbles out, collects
// store nibbles in and commits them to the local byte array in one cycle.
module mem_nibble_responder
    import mem_nib_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = ""
) (
    input logic                   memClk,
    input logic                   rst,
    mem_nibble_responder_if.slave bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        type_q, type_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rd_buf_q, rd_buf_d;
    logic [31:0]       wr_buf_q, wr_buf_d;
    logic [3:0]        nib_q, nib_d;
    logic [2:0]        pos_q, pos_d;
    logic              nib_valid_q, nib_valid_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;

    logic [3:0][7:0]   rd_bytes;
    logic [3:0]        wr_en;
    logic [3:0]        n_cur;
    logic [2:0]        wr_idx;
    logic              accept;
    logic              unused_addr;

    assign n_cur       = nib_count(type_q);
    assign wr_idx      = pos_dec(bus.dataPosIn);
    assign accept      = bus.reqValid && (bus.memType != MT_NONE);
    assign unused_addr = ^bus.spiAddr[23:ADDR_W];

    // Read lanes are addressed straight from the request so the accept edge can load rd_buf.
    nib_byte_store #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_store (
        .clk     (memClk),
        .rd_addr (bus.spiAddr[ADDR_W-1:0]),
        .rd_data (rd_bytes),
        .wr_addr (addr_q),
        .wr_en   (wr_en),
        .wr_data (wr_buf_q)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        rd_buf_d    = rd_buf_q;
        wr_buf_d    = wr_buf_q;
        nib_d       = nib_q;
        pos_d       = pos_q;
        nib_valid_d = nib_valid_q;
        ready_d     = 1'b0;
        perr_d      = perr_q;
        wr_en       = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = bus.spiAddr[ADDR_W-1:0];
                    type_d = bus.memType;
                    perr_d = 1'b0;
                    if (bus.reqWrite) begin
                        cnt_d    = 4'd0;
                        wr_buf_d = '0;
                        state_d  = ST_COLLECT;
                    end else begin
                        rd_buf_d    = rd_bytes;
                        nib_d       = rd_bytes[0][3:0];
                        pos_d       = pos_enc(3'd0);
                        nib_valid_d = 1'b1;
                        cnt_d       = 4'd1;
                        state_d     = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                if (cnt_q >= n_cur) begin
                    nib_valid_d = 1'b0;
                    nib_d       = 4'd0;
                    pos_d       = 3'd0;
                    ready_d     = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    nib_d = rd_buf_q[{cnt_q[2:0], 2'b00} +: 4];
                    pos_d = pos_enc(cnt_q[2:0]);
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_COLLECT: begin
                if (bus.wrValid) begin
                    // Positions beyond the transfer size are dropped and flagged, never counted.
                    if ({1'b0, wr_idx} >= n_cur) begin
                        perr_d = 1'b1;
                    end else begin
                        wr_buf_d[{wr_idx, 2'b00} +: 4] = bus.memDataIn;
                        cnt_d = cnt_q + 4'd1;
                        if ((cnt_q + 4'd1) >= n_cur) state_d = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: begin
                wr_en   = byte_mask(n_cur);
                ready_d = 1'b1;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge memClk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            type_q      <= MT_NONE;
            cnt_q       <= 4'd0;
            rd_buf_q    <= 32'd0;
            wr_buf_q    <= 32'd0;
            nib_q       <= 4'd0;
            pos_q       <= 3'd0;
            nib_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            rd_buf_q    <= rd_buf_d;
            wr_buf_q    <= wr_buf_d;
            nib_q       <= nib_d;
            pos_q       <= pos_d;
            nib_valid_q <= nib_valid_d;
            ready_q     <= ready_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.memDataOut = nib_q;
    assign bus.dataPosOut = pos_q;
    assign bus.nibValid   = nib_valid_q;
    assign bus.memReady   = ready_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.protoErr   = perr_q;

endmodule
